multi_register: RTL and testbench
=================================

MULTI_REGISTER -- requirements
Module: multi_register

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH  8  data width in bits, minimum 2
  AMT_W  3  shift-count field width; shift length N = amt+1, range 1..2^AMT_W
  SAT    0  0 = inc/dec wrap, 1 = inc/dec saturate
REQ-002 Ports SHALL be, one per line:
  clk    in   1        single clock, rising edge
  rst    in   1        synchronous reset, active-high
  cl     in   1        clear command
  ld     in   1        parallel load command
  inc    in   1        increment command
  dec    in   1        decrement command
  sr     in   1        shift-right command
  ir     in   1        right-shift serial fill bit, enters MSB
  sl     in   1        shift-left command
  il     in   1        left-shift serial fill bit, enters LSB
  rot    in   1        1 = shifts rotate; ir and il are ignored
  amt    in   AMT_W    shift length minus one
  in     in   WIDTH    parallel load data
  out    out  WIDTH    register contents
  busy   out  1        multi-cycle shift in progress
  done   out  1        one-cycle pulse when a shift operation completes
  carry  out  1        one-cycle pulse on inc/dec overflow or underflow
REQ-003 The block SHALL have one clock domain (clk), reset SHALL be synchronous and active-high (rst), and all outputs SHALL be registered.

Function
REQ-004 When idle (busy=0), commands SHALL be decoded with priority cl > ld > inc > dec > sr > sl; with no command asserted, out SHALL hold.
REQ-005 cl SHALL set out=0; ld SHALL set out=in; each SHALL take effect at the next edge.
REQ-006 With SAT=0, inc/dec SHALL be modulo 2^WIDTH: 0xFF+1=0x00 and 0x00-1=0xFF at WIDTH=8.
REQ-007 With SAT=1, inc at all-ones and dec at zero SHALL leave out unchanged.
REQ-008 carry SHALL be 1 for exactly the cycle after an inc accepted at all-ones or a dec accepted at zero, in both SAT modes, and 0 otherwise.
REQ-009 Shift acceptance SHALL latch direction (sr wins over sl), rot, the fill bit (ir for right, il for left) and N = amt+1. The first one-position shift SHALL be applied at the accepting edge.
REQ-010 Each subsequent edge SHALL apply one more one-position shift using the latched values, so exactly N shifts occur on N consecutive edges.
REQ-011 Right shift SHALL be out >> 1 with MSB = the fill bit, or with MSB = the old LSB when rot=1.
REQ-012 Left shift SHALL be out << 1 with LSB = the fill bit, or with LSB = the old MSB when rot=1.
REQ-013 The state machine SHALL have two states, IDLE and SHIFT. For N>1, acceptance SHALL move IDLE->SHIFT with busy=1 after the accepting edge. The edge applying the Nth shift SHALL return SHIFT->IDLE with busy=0.
REQ-014 done SHALL be 1 for exactly the cycle following the edge that applies the Nth shift, including N=1. For N=1, busy SHALL never assert.
REQ-015 In SHIFT, ld, inc, dec, sr and sl SHALL be ignored, and changes on amt, ir, il and rot SHALL have no effect.
REQ-016 In SHIFT, cl SHALL abort: at the next edge out=0, state=IDLE, busy=0, and done SHALL not pulse.
REQ-017 A new command SHALL be accepted on the first edge at which busy=0, including the cycle in which done=1.
REQ-018 The internal remaining-shift counter SHALL be AMT_W+1 bits wide, and N=2^AMT_W SHALL be supported without overflow.

Reset
REQ-019 rst=1 at a rising edge SHALL set out=0, busy=0, done=0, carry=0 and state=IDLE. This SHALL override all commands, including mid-shift, and discard the latched shift parameters.
REQ-020 No output SHALL change asynchronously to clk.

Verification (WIDTH=8, AMT_W=3)
REQ-021 Reset: hold rst=1 for 2 cycles with ld=1, in=0xFF -> out=0x00, busy=0, done=0, carry=0.
REQ-022 Multi-cycle shift: ld 0xA5, then sr=1, amt=2, ir=1, rot=0 for one cycle -> out=0xD2, 0xE9, 0xF4 on successive edges; busy=1 after the first two edges; done=1 in the cycle after the third edge only.
REQ-023 Single rotate: ld 0x81, then sl=1, amt=0, rot=1, il=0 -> out=0x03; done=1 for one cycle; busy stays 0.
REQ-024 Overflow: SAT=0, ld 0xFF, inc -> out=0x00, carry=1 for one cycle. SAT=1, same stimulus -> out=0xFF, carry=1. SAT=0, dec at 0x00 -> out=0xFF, carry=1.
REQ-025 Busy lockout and abort: ld 0x80, sr amt=7 ir=0 -> out=0x40, 0x20, 0x10. Then assert ld, in=0x55 for one cycle -> ignored, out=0x08. Then cl -> out=0x00, busy=0, no done pulse.
REQ-026 Reset mid-shift: start sr amt=7 from 0xFF and assert rst on the 3rd shift edge -> out=0x00, busy=0, done=0. The next command is accepted from IDLE with fresh amt.

Source files
------------

// File: rtl/multi_register_if.sv
// Command/status bundle for multi_register: one-hot-ish command strobes in,
// registered contents and status pulses out.
interface multi_register_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             cl;
  logic             ld;
  logic             inc;
  logic             dec;
  logic             sr;
  logic             ir;
  logic             sl;
  logic             il;
  logic             rot;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             carry;

  modport master (
    output cl, ld, inc, dec, sr, ir, sl, il, rot, amt, in,
    input  out, busy, done, carry
  );

  modport slave (
    input  cl, ld, inc, dec, sr, ir, sl, il, rot, amt, in,
    output out, busy, done, carry
  );
endinterface

// File: rtl/multi_register.sv
// Multi-function register: clear, load, inc/dec (wrap or saturate) and
// multi-cycle shift/rotate of amt+1 positions with busy/done handshake.
module multi_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3,
  parameter int SAT   = 0
) (
  input logic            clk,
  input logic            rst,
  multi_register_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [AMT_W:0]   CNT_ONE = (AMT_W+1)'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic [AMT_W:0]   r_cnt, w_cnt_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_rot, w_rot_nxt;
  logic             r_fill, w_fill_nxt;
  logic             r_busy, r_done, w_done_nxt, r_carry, w_carry_nxt;

  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] v,
                                               input logic right,
                                               input logic rot,
                                               input logic fill);
    if (right) return {(rot ? v[0] : fill), v[WIDTH-1:1]};
    else       return {v[WIDTH-2:0], (rot ? v[WIDTH-1] : fill)};
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_rot_nxt   = r_rot;
    w_fill_nxt  = r_fill;
    w_done_nxt  = 1'b0;
    w_carry_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cl) begin
          w_out_nxt = '0;
        end else if (bus.ld) begin
          w_out_nxt = bus.in;
        end else if (bus.inc) begin
          if (&r_out) begin
            w_carry_nxt = 1'b1;
            if (SAT == 0) w_out_nxt = '0;
          end else begin
            w_out_nxt = r_out + ONE;
          end
        end else if (bus.dec) begin
          if (r_out == '0) begin
            w_carry_nxt = 1'b1;
            if (SAT == 0) w_out_nxt = '1;
          end else begin
            w_out_nxt = r_out - ONE;
          end
        end else if (bus.sr || bus.sl) begin
          // First shift lands on the accepting edge; r_cnt holds the N-1 still owed.
          w_dir_nxt  = bus.sr;
          w_rot_nxt  = bus.rot;
          w_fill_nxt = bus.sr ? bus.ir : bus.il;
          w_out_nxt  = f_shift(r_out, bus.sr, bus.rot, w_fill_nxt);
          if (bus.amt == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_cnt_nxt   = {1'b0, bus.amt};
            w_state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (bus.cl) begin
          w_out_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_out_nxt = f_shift(r_out, r_dir, r_rot, r_fill);
          if (r_cnt == CNT_ONE) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
      r_fill  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_rot   <= w_rot_nxt;
      r_fill  <= w_fill_nxt;
      r_busy  <= (w_state_nxt == SHIFT);
      r_done  <= w_done_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign bus.out   = r_out;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.carry = r_carry;

endmodule

// File: tb/tb_multi_register.sv
// Bench for multi_register: directed scenarios plus random commands, checked
// every cycle against a queue-of-future-values reference model.
module tb_multi_register;
  localparam int W   = 8;
  localparam int A   = 3;
  localparam int MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_register_if #(.WIDTH(W), .AMT_W(A)) b0 ();
  multi_register_if #(.WIDTH(W), .AMT_W(A)) b1 ();

  multi_register #(.WIDTH(W), .AMT_W(A), .SAT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  multi_register #(.WIDTH(W), .AMT_W(A), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_checks = 0;
  int n_err    = 0;

  // Wrap-mode model: a pending shift is the list of values out will take.
  int m_out, m_busy, m_done, m_carry;
  int m_q[$];
  // Saturating-mode model (that instance only ever sees cl/ld/inc/dec).
  int s_out, s_carry;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int shift1(input int v, input bit right, input bit rot, input bit fill);
    int b;
    if (right) begin
      b = rot ? (v & 1) : int'(fill);
      return (v >> 1) | (b << (W - 1));
    end
    b = rot ? ((v >> (W - 1)) & 1) : int'(fill);
    return ((v << 1) & MAX) | b;
  endfunction

  task automatic model();
    if (rst) begin
      m_out = 0; m_q.delete(); m_busy = 0; m_done = 0; m_carry = 0;
      s_out = 0; s_carry = 0;
      return;
    end
    m_done = 0; m_carry = 0;
    if (m_q.size() > 0) begin
      if (b0.cl) begin
        m_out = 0; m_q.delete();
      end else begin
        m_out  = m_q.pop_front();
        m_done = (m_q.size() == 0);
      end
    end else if (b0.cl)  m_out = 0;
    else if (b0.ld)      m_out = int'(b0.in);
    else if (b0.inc) begin
      m_carry = (m_out == MAX);
      m_out   = (m_out + 1) % (MAX + 1);
    end else if (b0.dec) begin
      m_carry = (m_out == 0);
      m_out   = (m_out + MAX) % (MAX + 1);
    end else if (b0.sr || b0.sl) begin
      int v = m_out;
      for (int n = 0; n <= int'(b0.amt); n++) begin
        v = shift1(v, b0.sr, b0.rot, b0.sr ? b0.ir : b0.il);
        m_q.push_back(v);
      end
      m_out  = m_q.pop_front();
      m_done = (m_q.size() == 0);
    end
    m_busy = (m_q.size() > 0);

    s_carry = 0;
    if (b1.cl)       s_out = 0;
    else if (b1.ld)  s_out = int'(b1.in);
    else if (b1.inc) begin
      s_carry = (s_out == MAX);
      if (s_out != MAX) s_out++;
    end else if (b1.dec) begin
      s_carry = (s_out == 0);
      if (s_out != 0) s_out--;
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    check("out",    b0.out,   m_out);
    check("busy",   b0.busy,  m_busy);
    check("done",   b0.done,  m_done);
    check("carry",  b0.carry, m_carry);
    check("s_out",  b1.out,   s_out);
    check("s_carry", b1.carry, s_carry);
    check("s_busy", b1.busy,  0);
  endtask

  task automatic idle();
    b0.cl = 0; b0.ld = 0; b0.inc = 0; b0.dec = 0; b0.sr = 0; b0.sl = 0;
    b0.ir = 0; b0.il = 0; b0.rot = 0; b0.amt = '0; b0.in = '0;
    b1.cl = 0; b1.ld = 0; b1.inc = 0; b1.dec = 0; b1.sr = 0; b1.sl = 0;
    b1.ir = 0; b1.il = 0; b1.rot = 0; b1.amt = '0; b1.in = '0;
  endtask

  initial begin
    idle();
    m_out = 0; m_busy = 0; m_done = 0; m_carry = 0; s_out = 0; s_carry = 0;

    // Reset dominates a simultaneous load
    rst = 1; b0.ld = 1; b0.in = 8'hFF; b1.ld = 1; b1.in = 8'hFF;
    step(); step();
    check("rst_out", b0.out, 8'h00); check("rst_busy", b0.busy, 0);
    check("rst_done", b0.done, 0);   check("rst_carry", b0.carry, 0);
    rst = 0; idle();

    // Three-position right shift with fill 1
    b0.ld = 1; b0.in = 8'hA5; step(); idle();
    b0.sr = 1; b0.amt = 3'd2; b0.ir = 1; step(); idle();
    check("sr_e1", b0.out, 8'hD2); check("sr_b1", b0.busy, 1);
    step(); check("sr_e2", b0.out, 8'hE9); check("sr_b2", b0.busy, 1); check("sr_d2", b0.done, 0);
    step(); check("sr_e3", b0.out, 8'hF4); check("sr_b3", b0.busy, 0); check("sr_d3", b0.done, 1);
    step(); check("sr_d4", b0.done, 0);

    // Single left rotate
    b0.ld = 1; b0.in = 8'h81; step(); idle();
    b0.sl = 1; b0.rot = 1; b0.il = 0; step(); idle();
    check("rot_out", b0.out, 8'h03); check("rot_busy", b0.busy, 0); check("rot_done", b0.done, 1);
    step(); check("rot_done2", b0.done, 0);

    // Overflow / underflow in both modes
    b0.ld = 1; b0.in = 8'hFF; b1.ld = 1; b1.in = 8'hFF; step(); idle();
    b0.inc = 1; b1.inc = 1; step(); idle();
    check("ovf_out", b0.out, 8'h00); check("ovf_c", b0.carry, 1);
    check("sat_out", b1.out, 8'hFF); check("sat_c", b1.carry, 1);
    step(); check("ovf_c2", b0.carry, 0); check("sat_c2", b1.carry, 0);
    b0.dec = 1; step(); idle();
    check("udf_out", b0.out, 8'hFF); check("udf_c", b0.carry, 1);

    // Busy lockout then abort by clear
    b0.ld = 1; b0.in = 8'h80; step(); idle();
    b0.sr = 1; b0.amt = 3'd7; b0.ir = 0; step(); idle();
    check("lk_e1", b0.out, 8'h40);
    step(); check("lk_e2", b0.out, 8'h20);
    step(); check("lk_e3", b0.out, 8'h10);
    b0.ld = 1; b0.in = 8'h55; b0.amt = 3'd0; b0.ir = 1; step(); idle();
    check("lk_ign", b0.out, 8'h08); check("lk_busy", b0.busy, 1);
    b0.cl = 1; step(); idle();
    check("ab_out", b0.out, 8'h00); check("ab_busy", b0.busy, 0); check("ab_done", b0.done, 0);
    step(); check("ab_done2", b0.done, 0);

    // Reset on the third shift edge, then a fresh two-position shift
    b0.ld = 1; b0.in = 8'hFF; step(); idle();
    b0.sr = 1; b0.amt = 3'd7; step(); idle();
    step();
    rst = 1; step(); rst = 0;
    check("rm_out", b0.out, 8'h00); check("rm_busy", b0.busy, 0); check("rm_done", b0.done, 0);
    b0.sr = 1; b0.amt = 3'd1; b0.ir = 1; step(); idle();
    check("rm_n1", b0.out, 8'h80); check("rm_nb", b0.busy, 1);
    step(); check("rm_n2", b0.out, 8'hC0); check("rm_nd", b0.done, 1);

    // Random commands, including full-length shifts and mid-shift resets
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 99) < 2);
      b0.cl  = ($urandom_range(0, 19) == 0);
      b0.ld  = ($urandom_range(0, 5) == 0);
      b0.inc = ($urandom_range(0, 3) == 0);
      b0.dec = ($urandom_range(0, 3) == 0);
      b0.sr  = ($urandom_range(0, 3) == 0);
      b0.sl  = ($urandom_range(0, 3) == 0);
      b0.ir  = 1'($urandom); b0.il = 1'($urandom); b0.rot = 1'($urandom);
      b0.amt = A'($urandom);
      b0.in  = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
      b1.cl  = ($urandom_range(0, 29) == 0);
      b1.ld  = ($urandom_range(0, 7) == 0);
      b1.inc = ($urandom_range(0, 1) == 0);
      b1.dec = ($urandom_range(0, 2) == 0);
      b1.in  = ($urandom_range(0, 1) == 0) ? 8'hFE : 8'h01;
      step();
    end
    rst = 0; idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
